// File: rtl/mem_refill_ctrl_if.sv
// Cache-side request/response and word-wide memory bus of the refill controller.
interface mem_refill_ctrl_if #(
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_WIDTH      = 32
);
  logic                                  req_valid;
  logic                                  req_ready;
  logic                                  req_fill;
  logic                                  req_wb;
  logic [ADDR_WIDTH-1:0]                 req_addr;
  logic [ADDR_WIDTH-1:0]                 req_wb_addr;
  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] req_wdata;
  logic                                  resp_valid;
  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] resp_rdata;
  logic                                  mem_en;
  logic                                  mem_we;
  logic [ADDR_WIDTH-1:0]                 mem_addr;
  logic [WORD_WIDTH-1:0]                 mem_wdata;
  logic [WORD_WIDTH-1:0]                 mem_rdata;
  logic                                  mem_ack;

  // controller view
  modport slave (
    input  req_valid, req_fill, req_wb, req_addr, req_wb_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // cache + memory environment view
  modport master (
    output req_valid, req_fill, req_wb, req_addr, req_wb_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_refill_ctrl.sv
// Block refill / write-back sequencer between data cache and word-wide memory.
// Optional MEM_CTRL_PERF_CNT_EN adds transaction and busy-cycle counters.
module mem_refill_ctrl #(
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_WIDTH      = 32
) (
  input logic              clk,
  input logic              reset,
  mem_refill_ctrl_if.slave bus
`ifdef MEM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_txn_cnt,
  output logic [31:0]      perf_busy_cnt
`endif
);
  localparam int IW = $clog2(WORDS_PER_BLOCK);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(WORDS_PER_BLOCK*4-1);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_e;
  typedef logic [WORDS_PER_BLOCK-1:0][WORD_WIDTH-1:0] blk_t;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] fill_base_q, fill_base_d;
  logic [ADDR_WIDTH-1:0] wb_base_q, wb_base_d;
  blk_t                  wdata_q, wdata_d;
  blk_t                  rdata_q, rdata_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;

  blk_t          req_blk;
  logic          last_word;
  logic [IW-1:0] idx_nxt;

  assign req_blk   = bus.req_wdata;
  assign last_word = (idx_q == IW'(WORDS_PER_BLOCK-1));
  assign idx_nxt   = idx_q + 1'b1;

  // Base has its offset bits cleared, so OR-ing the word offset is an add.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [IW-1:0] i);
    return base | ADDR_WIDTH'({i, 2'b00});
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    fill_base_d  = fill_base_q;
    wb_base_d    = wb_base_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && (bus.req_wb || bus.req_fill)) begin
          fill_d      = bus.req_fill;
          fill_base_d = bus.req_addr & BASE_MASK;
          wb_base_d   = bus.req_wb_addr & BASE_MASK;
          wdata_d     = req_blk;
          idx_d       = '0;
          mem_en_d    = 1'b1;
          if (bus.req_wb) begin
            state_d     = WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.req_wb_addr & BASE_MASK;
            mem_wdata_d = req_blk[0];
          end else begin
            state_d    = FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.req_addr & BASE_MASK;
          end
        end
      end
      WB: begin
        if (bus.mem_ack) begin
          if (!last_word) begin
            idx_d       = idx_nxt;
            mem_addr_d  = word_addr(wb_base_q, idx_nxt);
            mem_wdata_d = wdata_q[idx_nxt];
          end else if (fill_q) begin
            state_d    = FILL;
            idx_d      = '0;
            mem_we_d   = 1'b0;
            mem_addr_d = fill_base_q;
          end else begin
            state_d      = RESP;
            mem_en_d     = 1'b0;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          rdata_d[idx_q] = bus.mem_rdata;
          if (!last_word) begin
            idx_d      = idx_nxt;
            mem_addr_d = word_addr(fill_base_q, idx_nxt);
          end else begin
            state_d      = RESP;
            mem_en_d     = 1'b0;
            resp_valid_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      fill_q       <= 1'b0;
      fill_base_q  <= '0;
      wb_base_q    <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      fill_base_q  <= fill_base_d;
      wb_base_q    <= wb_base_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

`ifdef MEM_CTRL_PERF_CNT_EN
  logic [31:0] txn_cnt_q, txn_cnt_d;
  logic [31:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    txn_cnt_d  = txn_cnt_q + 32'(state_q == RESP);
    busy_cnt_d = busy_cnt_q + 32'(state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txn_cnt_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      txn_cnt_q  <= txn_cnt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign perf_txn_cnt  = txn_cnt_q;
  assign perf_busy_cnt = busy_cnt_q;
`endif
endmodule
